// File: rtl/cardinal_vc_port.sv
// cardinal_vc_port: two-virtual-channel (even/odd) router input port.
// Holds one packet per VC. Packets are taken from the NIC over the si/ri
// handshake and passed on downstream when the global polarity selects that VC.
// The module also drives the free-running even/odd polarity that the NIC uses
// to time its sends.
module cardinal_vc_port #(
    parameter int DATA_WIDTH = 64,
    parameter int VC_BIT     = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic                  polarity,
    input  logic                  up_si,
    output logic                  up_ri,
    input  logic [DATA_WIDTH-1:0] up_di,
    output logic                  down_so,
    input  logic                  down_ro,
    output logic [DATA_WIDTH-1:0] down_do,
    output logic                  drop_err,
    output logic [1:0]            vc_full
);

    // Polarity register: 0 selects the even VC, 1 selects the odd VC.
    logic                  p_q;
    logic                  p_d;

    // Occupancy flags and the one-entry buffer for each VC.
    logic [1:0]            full_q;
    logic [1:0]            full_d;
    logic [DATA_WIDTH-1:0] vcbuf_q [2];
    logic [DATA_WIDTH-1:0] vcbuf_d [2];

    // Registered downstream outputs and the sticky overflow flag.
    logic                  so_q;
    logic                  so_d;
    logic [DATA_WIDTH-1:0] do_q;
    logic [DATA_WIDTH-1:0] do_d;
    logic                  err_q;
    logic                  err_d;

    // Decoded events for the current cycle.
    logic                  up_vc;
    logic                  acc_en;
    logic                  drop_en;
    logic                  fwd_en;

    // Classify this cycle's upstream and downstream events.
    always_comb begin
        up_vc   = up_di[VC_BIT];
        // down_ro only matters when the VC selected by polarity has a packet.
        fwd_en  = full_q[p_q] && down_ro;
        // Accept and drop look only at occupancy at the start of the cycle.
        // A packet for the VC that is being drained on this edge sees a full
        // buffer, so it is dropped rather than written through.
        acc_en  = up_si && !full_q[up_vc];
        drop_en = up_si &&  full_q[up_vc];
    end

    // Next-state logic for polarity, buffers, occupancy and outputs.
    always_comb begin
        p_d        = ~p_q;
        full_d     = full_q;
        vcbuf_d[0] = vcbuf_q[0];
        vcbuf_d[1] = vcbuf_q[1];
        so_d       = 1'b0;
        do_d       = do_q;
        err_d      = err_q | drop_en;

        if (fwd_en) begin
            full_d[p_q] = 1'b0;
            so_d        = 1'b1;
            do_d        = vcbuf_q[p_q];
        end

        // When up_vc equals p_q, fwd_en requires a full buffer and acc_en
        // requires an empty one, so the two writes below never target the
        // same flag.
        if (acc_en) begin
            full_d[up_vc]  = 1'b1;
            vcbuf_d[up_vc] = up_di;
        end
    end

    // State register. Reset clears everything and takes priority over any
    // handshake on the same edge, so an in-flight packet is discarded.
    always_ff @(posedge clk) begin
        if (!reset) begin
            p_q        <= 1'b0;
            full_q     <= 2'b00;
            vcbuf_q[0] <= '0;
            vcbuf_q[1] <= '0;
            so_q       <= 1'b0;
            do_q       <= '0;
            err_q      <= 1'b0;
        end else begin
            p_q        <= p_d;
            full_q     <= full_d;
            vcbuf_q[0] <= vcbuf_d[0];
            vcbuf_q[1] <= vcbuf_d[1];
            so_q       <= so_d;
            do_q       <= do_d;
            err_q      <= err_d;
        end
    end

    // Output mapping. up_ri advertises the buffer whose VC equals the current
    // polarity. The NIC commits on the next edge, when the polarity has flipped.
    always_comb begin
        polarity = p_q;
        up_ri    = !full_q[p_q];
        down_so  = so_q;
        down_do  = do_q;
        drop_err = err_q;
        vc_full  = full_q;
    end

endmodule

// File: tb/tb_cardinal_vc_port.sv
// Directed bench for cardinal_vc_port: reset, single packet, backpressure,
// overflow, dual-VC drain and reset during operation.
module tb_cardinal_vc_port;

    logic        clk;
    logic        reset;
    logic        polarity;
    logic        up_si;
    logic        up_ri;
    logic [63:0] up_di;
    logic        down_so;
    logic        down_ro;
    logic [63:0] down_do;
    logic        drop_err;
    logic [1:0]  vc_full;

    int vectors;
    int miscompares;

    cardinal_vc_port #(
        .DATA_WIDTH(64),
        .VC_BIT    (0)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .polarity(polarity),
        .up_si   (up_si),
        .up_ri   (up_ri),
        .up_di   (up_di),
        .down_so (down_so),
        .down_ro (down_ro),
        .down_do (down_do),
        .drop_err(drop_err),
        .vc_full (vc_full)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance one clock edge, then settle 1 time unit before sampling or driving.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic exp_p;
        vectors     = 0;
        miscompares = 0;

        // Reset held for 3 edges while upstream tries to send.
        reset   = 1'b0;
        up_si   = 1'b1;
        up_di   = 64'h5;
        down_ro = 1'b0;
        step(); step(); step();
        chk("rst_vc_full",  64'(vc_full),  64'd0);
        chk("rst_down_so",  64'(down_so),  64'd0);
        chk("rst_down_do",  down_do,       64'd0);
        chk("rst_drop_err", 64'(drop_err), 64'd0);
        chk("rst_polarity", 64'(polarity), 64'd0);
        chk("rst_up_ri",    64'(up_ri),    64'd1);

        // Release reset: polarity sequence 0 (above), 1, 0, 1.
        reset = 1'b1;
        up_si = 1'b0;
        step(); chk("pol_seq1", 64'(polarity), 64'd1);
        step(); chk("pol_seq2", 64'(polarity), 64'd0);
        step(); chk("pol_seq3", 64'(polarity), 64'd1);
        chk("idle_down_so", 64'(down_so), 64'd0);

        // Single even packet, accepted at an edge with p=1.
        up_si   = 1'b1;
        up_di   = 64'hA5A5_0000_0000_0010;
        down_ro = 1'b1;
        chk("even_up_ri", 64'(up_ri), 64'd1);
        step();
        up_si = 1'b0;
        chk("even_acc_full", 64'(vc_full), 64'd1);
        chk("even_acc_so",   64'(down_so), 64'd0);
        step();
        chk("even_fwd_so",   64'(down_so), 64'd1);
        chk("even_fwd_do",   down_do,      64'hA5A5_0000_0000_0010);
        chk("even_fwd_full", 64'(vc_full), 64'd0);
        step();
        chk("even_once_so",  64'(down_so), 64'd0);
        chk("even_hold_do",  down_do,      64'hA5A5_0000_0000_0010);

        // Backpressure on the odd VC (p=0 now).
        up_si   = 1'b1;
        up_di   = 64'h1;
        down_ro = 1'b0;
        step();
        up_si = 1'b0;
        chk("bp_full",     64'(vc_full),  64'd2);
        chk("bp_pol",      64'(polarity), 64'd1);
        chk("bp_up_ri_p1", 64'(up_ri),    64'd0);
        exp_p = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            exp_p = ~exp_p;
            chk("bp_hold_so",   64'(down_so),  64'd0);
            chk("bp_hold_full", 64'(vc_full),  64'd2);
            chk("bp_hold_pol",  64'(polarity), 64'(exp_p));
            chk("bp_hold_ri",   64'(up_ri),    exp_p ? 64'd0 : 64'd1);
        end
        down_ro = 1'b1;
        step();
        chk("bp_fwd_so",   64'(down_so), 64'd1);
        chk("bp_fwd_do",   down_do,      64'h1);
        chk("bp_fwd_full", 64'(vc_full), 64'd0);
        step(); chk("bp_once_so1", 64'(down_so), 64'd0);
        step(); chk("bp_once_so2", 64'(down_so), 64'd0);

        // Overflow: two odd packets while stalled (p=0 now).
        down_ro = 1'b0;
        up_si   = 1'b1;
        up_di   = 64'h3;
        step();
        chk("ovf_first_full", 64'(vc_full),  64'd2);
        chk("ovf_first_err",  64'(drop_err), 64'd0);
        up_di = 64'h7;
        step();
        up_si = 1'b0;
        chk("ovf_err",      64'(drop_err), 64'd1);
        chk("ovf_full",     64'(vc_full),  64'd2);
        step();
        chk("ovf_err_sticky", 64'(drop_err), 64'd1);
        chk("ovf_pol",        64'(polarity), 64'd1);
        down_ro = 1'b1;
        step();
        chk("ovf_fwd_so",   64'(down_so),  64'd1);
        chk("ovf_fwd_do",   down_do,       64'h3);
        chk("ovf_fwd_full", 64'(vc_full),  64'd0);
        step();
        chk("ovf_no7_so",   64'(down_so),  64'd0);
        chk("ovf_no7_do",   down_do,       64'h3);
        step();
        chk("ovf_no7_so2",  64'(down_so),  64'd0);
        chk("ovf_no7_do2",  down_do,       64'h3);
        chk("ovf_err_late", 64'(drop_err), 64'd1);

        // Dual VC: buffer even 2 then odd 5 while stalled (p=0 now).
        down_ro = 1'b0;
        up_si   = 1'b1;
        up_di   = 64'h2;
        step();
        up_di = 64'h5;
        step();
        up_si = 1'b0;
        chk("dual_full", 64'(vc_full),  64'd3);
        chk("dual_pol",  64'(polarity), 64'd0);
        down_ro = 1'b1;
        step();
        chk("dual_fwd0_so",   64'(down_so), 64'd1);
        chk("dual_fwd0_do",   down_do,      64'h2);
        chk("dual_fwd0_full", 64'(vc_full), 64'd2);
        step();
        chk("dual_fwd1_so",   64'(down_so), 64'd1);
        chk("dual_fwd1_do",   down_do,      64'h5);
        chk("dual_fwd1_full", 64'(vc_full), 64'd0);
        step();
        chk("dual_end_so",    64'(down_so), 64'd0);

        // Reset mid-operation with both buffers full (p=1 now).
        down_ro = 1'b0;
        up_si   = 1'b1;
        up_di   = 64'h9;
        step();
        up_di = 64'h4;
        step();
        up_si = 1'b0;
        chk("mid_full", 64'(vc_full), 64'd3);
        reset   = 1'b0;
        down_ro = 1'b1;
        step();
        chk("mid_rst_full", 64'(vc_full),  64'd0);
        chk("mid_rst_so",   64'(down_so),  64'd0);
        chk("mid_rst_pol",  64'(polarity), 64'd0);
        chk("mid_rst_err",  64'(drop_err), 64'd0);
        chk("mid_rst_do",   down_do,       64'd0);
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("mid_post_so",   64'(down_so), 64'd0);
            chk("mid_post_full", 64'(vc_full), 64'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/cardinal_vc_port.md
Name: cardinal_vc_port

Overview:
- Two-virtual-channel (even/odd) router input port. Sits directly downstream of the node NIC output channel and consumes its net_so/net_ro/net_do/net_polarity handshake.
- Buffers one packet per VC and forwards it toward the router switch / next hop using the same si/ri handshake.
- Generates the global even/odd polarity that the NIC uses to time its sends.

Parameters:
- DATA_WIDTH, 64, packet width in bits.
- VC_BIT, 0, bit index of the packet VC field (0 = even VC, 1 = odd VC).

Ports:
- clk  input  1  system clock, all state updates on posedge.
- reset  input  1  synchronous reset, active-low (state clears on posedge clk while reset==0).
- polarity  output  1  current polarity register p; drives NIC net_polarity.
- up_si  input  1  upstream send; packet on up_di is valid this cycle.
- up_ri  output  1  upstream ready; drives NIC net_ro.
- up_di  input  DATA_WIDTH  upstream packet data.
- down_so  output  1  downstream send, registered one-cycle pulse.
- down_ro  input  1  downstream ready.
- down_do  output  DATA_WIDTH  downstream packet data, registered.
- drop_err  output  1  sticky: a packet arrived for a full VC buffer.
- vc_full  output  2  occupancy flags; bit0 = even buffer, bit1 = odd buffer.

Behaviour:
- Reset (reset==0 at posedge):
  - p=0, both buffers cleared, vc_full=2'b00.
  - down_so=0, down_do=0, drop_err=0.
  - Reset dominates any simultaneous handshake; an in-flight packet is discarded.
- Polarity: p toggles every cycle after reset deasserts (0,1,0,1...). polarity = p, registered.
- up_ri: combinational, up_ri = !vc_full[p]. It advertises the buffer whose VC equals the current polarity. The sender commits that packet on the next edge, so it arrives while p has flipped.
- Upstream accept, at posedge:
  - Let v = up_di[VC_BIT].
  - If up_si && !vc_full[v]: buf[v] <= up_di and vc_full[v] <= 1. The VC bit is not modified.
  - If up_si && vc_full[v]: the packet is dropped, the buffer is unchanged, and drop_err <= 1. drop_err is cleared only by reset.
- Downstream forward, at posedge in a cycle with polarity p:
  - If vc_full[p] && down_ro: down_do <= buf[p], down_so <= 1, vc_full[p] <= 0.
  - Otherwise down_so <= 0 and down_do holds its last value.
  - down_so is asserted for exactly one cycle per packet.
- Latency: minimum 1 cycle from accept edge to forward edge, when the packet VC equals the next polarity. Otherwise 2 cycles. Each further cycle with down_ro==0 adds 2 cycles.
- Simultaneous events:
  - Accept into buf[v] and forward from buf[p] on the same edge is legal when v != p.
  - When v == p, forward requires full and accept requires empty, so the two are mutually exclusive. No same-edge write-after-drain bypass: a packet arriving for a VC being drained that edge is dropped.
- Accepts and forwards on both VCs are independent; both buffers may be full at once.
- Ordering: FIFO within one VC (depth 1). No ordering guarantee between VCs.
- up_di is ignored when up_si==0. down_ro is sampled only when vc_full[p]==1.

Test Plan:
- Reset: hold reset=0 for 3 cycles with up_si=1 and up_di=64'h5 -> vc_full=00, down_so=0, down_do=0, drop_err=0, polarity=0. After release, polarity reads 0,1,0,1 on successive cycles.
- Single packet, even VC: accept up_di=64'hA5A5_0000_0000_0010 (bit0=0) at an edge with p=1, down_ro=1 -> next edge (p=0): down_so=1 for one cycle, down_do=64'hA5A5_0000_0000_0010, vc_full=00.
- Backpressure: odd packet 64'h1 buffered, down_ro=0 for 6 cycles -> down_so=0, vc_full[1]=1, up_ri=0 in p=1 cycles. Set down_ro=1 -> forwarded at the first p=1 edge, exactly once.
- Overflow: two odd packets 64'h3 then 64'h7 with down_ro=0 -> buf[1] holds 64'h3, drop_err=1 and stays 1. After down_ro=1, 64'h3 is delivered and 64'h7 never appears.
- Dual VC: even 64'h2 and odd 64'h5 both buffered, down_ro=1 -> two down_so pulses on consecutive cycles, each with the data of the VC matching that cycle's polarity.
- Reset mid-operation: vc_full=11, assert reset=0 for one edge -> vc_full=00, down_so=0, polarity=0. No buffered packet is emitted after reset releases.
